// File: rtl/useq_controller_pkg.sv
// Shared definitions for the microsequenced controller: opcode classes,
// micro-word NEXT encoding, FSM states and micro-word field layout.
package useq_controller_pkg;

    localparam logic [6:0] TYPE_R      = 7'b0110011;
    localparam logic [6:0] TYPE_I_COMP = 7'b0010011;
    localparam logic [6:0] TYPE_I_LOAD = 7'b0000011;
    localparam logic [6:0] TYPE_I_JALR = 7'b1100111;
    localparam logic [6:0] TYPE_S      = 7'b0100011;
    localparam logic [6:0] TYPE_SB     = 7'b1100011;

    typedef enum logic [1:0] {
        N_END  = 2'b00,
        N_SEQ  = 2'b01,
        N_WAIT = 2'b10,
        N_ILL  = 2'b11
    } next_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_EXEC  = 2'b01,
        S_FAULT = 2'b10
    } state_e;

    // Micro-word is {NEXT, ctrl}: ctrl starts at bit 0, NEXT sits just above it.
    localparam int CTRL_LSB   = 0;
    localparam int NEXT_WIDTH = 2;
    localparam int DISP_WIDTH = 9;

endpackage

// File: rtl/useq_controller_if.sv
// Fetch, memory-status, datapath and programming signals of the controller.
interface useq_controller_if #(
    parameter int W_I = 10,
    parameter int W_C = 26
);
    logic           instr_valid;
    logic           instr_ready;
    logic [31:0]    instruction;
    logic           mem_ready;
    logic [W_C-1:0] ctrl;
    logic           ctrl_valid;
    logic           instr_done;
    logic           fault;
    logic           fault_clr;
    logic           prog_we;
    logic [W_I-1:0] prog_addr;
    logic [W_C+1:0] prog_data;

    modport master (
        output instr_valid, instruction, mem_ready, fault_clr,
               prog_we, prog_addr, prog_data,
        input  instr_ready, ctrl, ctrl_valid, instr_done, fault
    );

    modport slave (
        input  instr_valid, instruction, mem_ready, fault_clr,
               prog_we, prog_addr, prog_data,
        output instr_ready, ctrl, ctrl_valid, instr_done, fault
    );
endinterface

// File: rtl/useq_controller_dispatch.sv
// Combinational mapping of an RV32 instruction to its first micro-address
// in the lower (dispatch) half of the control store.
module useq_dispatch
    import useq_controller_pkg::*;
#(
    parameter int W_I = 10
) (
    input  logic [31:0]    instruction,
    output logic [W_I-1:0] dispatch_addr
);

    logic [2:0] f3;
    logic       b30;
    logic       unused_bits;

    assign unused_bits = ^{instruction[31], instruction[29:15], instruction[11:7], instruction[1:0]};

    // Only formats that actually carry funct3/bit30 contribute them, so other
    // opcodes land on a single dispatch slot regardless of their immediates.
    always_comb begin
        f3  = 3'b000;
        b30 = 1'b0;
        case (instruction[6:0])
            TYPE_R: begin
                f3  = instruction[14:12];
                b30 = instruction[30];
            end
            TYPE_I_COMP: begin
                f3  = instruction[14:12];
                b30 = (instruction[14:12] == 3'b101) ? instruction[30] : 1'b0;
            end
            TYPE_I_LOAD, TYPE_I_JALR, TYPE_S, TYPE_SB: begin
                f3  = instruction[14:12];
            end
            default: begin
                f3  = 3'b000;
                b30 = 1'b0;
            end
        endcase
        dispatch_addr                 = '0;
        dispatch_addr[DISP_WIDTH-1:0] = {instruction[6:2], f3, b30};
    end

endmodule

// File: rtl/useq_controller.sv
// Multi-cycle microsequenced controller: dispatches instructions into a
// writable control store and steps a micro-PC under a per-word NEXT field.
module useq_controller
    import useq_controller_pkg::*;
#(
    parameter int W_I         = 10,
    parameter int W_C         = 26,
    parameter int MAX_UCYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    useq_controller_if.slave   bus
);

    localparam int UCNT_W = $clog2(MAX_UCYCLES) + 1;

    logic [W_C+1:0]    store [2**W_I];
    state_e            state_q, state_d;
    logic [W_I-1:0]    upc_q, upc_d;
    logic [UCNT_W-1:0] ucnt_q, ucnt_d;
    logic [W_I-1:0]    dispatch_addr;
    logic [W_C+1:0]    uword;
    next_e             unext;

    useq_dispatch #(.W_I(W_I)) u_dispatch (
        .instruction   (bus.instruction),
        .dispatch_addr (dispatch_addr)
    );

    assign uword = store[upc_q];
    assign unext = next_e'(uword[W_C +: NEXT_WIDTH]);

    // Writes only land while idle with nothing being accepted, so a running
    // micro-program never sees its own store change underneath it.
    always_ff @(posedge clk) begin
        if (!rst && bus.prog_we && state_q == S_IDLE && !bus.instr_valid) begin
            store[bus.prog_addr] <= bus.prog_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            upc_q   <= '0;
            ucnt_q  <= '0;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            ucnt_q  <= ucnt_d;
        end
    end

    // END wins over the watchdog so an instruction finishing on its last
    // allowed micro-cycle still completes normally.
    always_comb begin
        state_d         = state_q;
        upc_d           = upc_q;
        ucnt_d          = ucnt_q;
        bus.ctrl        = '0;
        bus.ctrl_valid  = 1'b0;
        bus.instr_done  = 1'b0;
        bus.fault       = 1'b0;
        bus.instr_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.instr_ready = 1'b1;
                if (bus.instr_valid) begin
                    upc_d   = dispatch_addr;
                    ucnt_d  = '0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                bus.ctrl       = uword[CTRL_LSB +: W_C];
                bus.ctrl_valid = 1'b1;
                ucnt_d         = ucnt_q + 1'b1;
                if (unext == N_END) begin
                    bus.instr_done = 1'b1;
                    state_d        = S_IDLE;
                end else if (unext == N_ILL || ucnt_q == UCNT_W'(MAX_UCYCLES - 1)) begin
                    state_d = S_FAULT;
                end else if (unext == N_SEQ || bus.mem_ready) begin
                    upc_d = upc_q + 1'b1;
                end
            end
            S_FAULT: begin
                bus.fault = 1'b1;
                if (bus.fault_clr) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_useq_controller.sv
// Directed self-checking bench for useq_controller: dispatch, WAIT stalls,
// watchdog, illegal NEXT, dropped programming writes and async reset.
module tb_useq_controller;
    import useq_controller_pkg::*;

    localparam int W_I = 10;
    localparam int W_C = 26;

    localparam logic [31:0] I_ADD  = 32'h003100B3;
    localparam logic [31:0] I_SUB  = 32'h403100B3;
    localparam logic [31:0] I_SRLI = 32'h00315093;
    localparam logic [31:0] I_SRAI = 32'h40315093;
    localparam logic [31:0] I_LUI  = 32'h400050B7;
    localparam logic [31:0] I_ADDI = 32'h00100093;
    localparam logic [31:0] I_SW   = 32'h0020A023;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   n_exec, n_done, n_watch;

    always #5 clk = ~clk;

    useq_controller_if #(.W_I(W_I), .W_C(W_C)) bus ();

    useq_controller #(.W_I(W_I), .W_C(W_C), .MAX_UCYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic prog_write(input logic [W_I-1:0] addr, input next_e nxt, input logic [W_C-1:0] data);
        bus.prog_we   = 1'b1;
        bus.prog_addr = addr;
        bus.prog_data = {nxt, data};
        tick();
        bus.prog_we   = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [31:0] instr);
        bus.instr_valid = 1'b1;
        bus.instruction = instr;
        tick();
        bus.instr_valid = 1'b0;
    endtask

    // Counts EXEC cycles, done pulses and cycles showing a chosen ctrl value;
    // mem_ready rises once release_at EXEC cycles have been observed.
    task automatic run_cycles(input int n, input int release_at, input logic [W_C-1:0] watch,
                              output int exec_cnt, output int done_cnt, output int watch_cnt);
        exec_cnt  = 0;
        done_cnt  = 0;
        watch_cnt = 0;
        for (int i = 0; i < n; i++) begin
            if (bus.ctrl_valid) exec_cnt++;
            if (bus.instr_done) done_cnt++;
            if (bus.ctrl_valid && bus.ctrl == watch) watch_cnt++;
            bus.mem_ready = (exec_cnt >= release_at);
            tick();
        end
        bus.mem_ready = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instruction = '0;
        bus.mem_ready   = 1'b0;
        bus.fault_clr   = 1'b0;
        bus.prog_we     = 1'b0;
        bus.prog_addr   = '0;
        bus.prog_data   = '0;
        #1;
        check_output("rst_instr_ready", 32'(bus.instr_ready), 32'd1);
        check_output("rst_ctrl_valid",  32'(bus.ctrl_valid),  32'd0);
        check_output("rst_ctrl",        32'(bus.ctrl),        32'd0);
        check_output("rst_fault",       32'(bus.fault),       32'd0);
        check_output("rst_instr_done",  32'(bus.instr_done),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        $display("[TB] ADD single END word");
        prog_write(10'h0C0, N_END, 26'h155AAA);
        apply_stimulus(I_ADD);
        check_output("add_ctrl",        32'(bus.ctrl),        32'h155AAA);
        check_output("add_ctrl_valid",  32'(bus.ctrl_valid),  32'd1);
        check_output("add_instr_done",  32'(bus.instr_done),  32'd1);
        check_output("add_ready_busy",  32'(bus.instr_ready), 32'd0);
        tick();
        check_output("add_ready_back",  32'(bus.instr_ready), 32'd1);
        check_output("add_idle_ctrl",   32'(bus.ctrl),        32'd0);

        $display("[TB] dispatch addresses");
        prog_write(10'h0C1, N_END, 26'h0000C1);
        prog_write(10'h04A, N_END, 26'h00004A);
        prog_write(10'h04B, N_END, 26'h00004B);
        prog_write(10'h0D0, N_END, 26'h0000D0);
        apply_stimulus(I_SUB);
        check_output("sub_dispatch",  32'(bus.ctrl), 32'h0C1);
        tick();
        apply_stimulus(I_SRLI);
        check_output("srli_dispatch", 32'(bus.ctrl), 32'h04A);
        tick();
        apply_stimulus(I_SRAI);
        check_output("srai_dispatch", 32'(bus.ctrl), 32'h04B);
        tick();
        apply_stimulus(I_LUI);
        check_output("lui_dispatch",  32'(bus.ctrl), 32'h0D0);
        tick();

        $display("[TB] SEQ/WAIT/END with memory stall");
        prog_write(10'h040, N_SEQ,  26'h001111);
        prog_write(10'h041, N_WAIT, 26'h002222);
        prog_write(10'h042, N_END,  26'h003333);
        apply_stimulus(I_ADDI);
        run_cycles(10, 5, 26'h002222, n_exec, n_done, n_watch);
        check_output("wait_exec_cycles", 32'(n_exec),  32'd6);
        check_output("wait_held_cycles", 32'(n_watch), 32'd4);
        check_output("wait_done_pulses", 32'(n_done),  32'd1);
        check_output("wait_ready_after", 32'(bus.instr_ready), 32'd1);

        $display("[TB] watchdog on 16 SEQ words");
        for (int i = 0; i < 16; i++) begin
            prog_write(W_I'(10'h084 + i), N_SEQ, W_C'(26'h100 + i));
        end
        apply_stimulus(I_SW);
        run_cycles(20, 0, 26'h10F, n_exec, n_done, n_watch);
        check_output("wd_exec_cycles", 32'(n_exec),  32'd16);
        check_output("wd_last_word",   32'(n_watch), 32'd1);
        check_output("wd_no_done",     32'(n_done),  32'd0);
        check_output("wd_fault",       32'(bus.fault),      32'd1);
        check_output("wd_fault_ctrl",  32'(bus.ctrl),       32'd0);
        check_output("wd_fault_ready", 32'(bus.instr_ready), 32'd0);
        bus.fault_clr = 1'b1;
        tick();
        bus.fault_clr = 1'b0;
        check_output("wd_clr_fault", 32'(bus.fault),       32'd0);
        check_output("wd_clr_ready", 32'(bus.instr_ready), 32'd1);

        $display("[TB] END on the last allowed micro-cycle");
        prog_write(10'h093, N_END, 26'h000193);
        apply_stimulus(I_SW);
        run_cycles(20, 0, 26'h193, n_exec, n_done, n_watch);
        check_output("wdend_exec_cycles", 32'(n_exec),    32'd16);
        check_output("wdend_done",        32'(n_done),    32'd1);
        check_output("wdend_last_word",   32'(n_watch),   32'd1);
        check_output("wdend_no_fault",    32'(bus.fault), 32'd0);

        $display("[TB] illegal NEXT and write during EXEC");
        prog_write(10'h0C1, N_ILL, 26'h2ABCDE);
        apply_stimulus(I_SUB);
        check_output("ill_ctrl",       32'(bus.ctrl),       32'h2ABCDE);
        check_output("ill_ctrl_valid", 32'(bus.ctrl_valid), 32'd1);
        check_output("ill_no_done",    32'(bus.instr_done), 32'd0);
        bus.prog_we   = 1'b1;
        bus.prog_addr = 10'h0C0;
        bus.prog_data = {N_END, 26'h111111};
        tick();
        bus.prog_we = 1'b0;
        check_output("ill_fault",       32'(bus.fault),      32'd1);
        check_output("ill_fault_ctrl",  32'(bus.ctrl),       32'd0);
        check_output("ill_fault_valid", 32'(bus.ctrl_valid), 32'd0);
        bus.fault_clr = 1'b1;
        tick();
        bus.fault_clr = 1'b0;
        check_output("ill_clr_ready", 32'(bus.instr_ready), 32'd1);
        apply_stimulus(I_ADD);
        check_output("exec_write_dropped", 32'(bus.ctrl), 32'h155AAA);
        tick();

        $display("[TB] write coincident with acceptance");
        bus.prog_we   = 1'b1;
        bus.prog_addr = 10'h0C0;
        bus.prog_data = {N_END, 26'h222222};
        apply_stimulus(I_ADD);
        bus.prog_we = 1'b0;
        check_output("accept_write_dropped", 32'(bus.ctrl), 32'h155AAA);
        tick();

        $display("[TB] async reset mid-WAIT");
        bus.mem_ready = 1'b0;
        apply_stimulus(I_ADDI);
        tick();
        tick();
        check_output("rstw_in_wait", 32'(bus.ctrl), 32'h002222);
        #1;
        rst = 1'b1;
        #1;
        check_output("rstw_instr_ready", 32'(bus.instr_ready), 32'd1);
        check_output("rstw_ctrl_valid",  32'(bus.ctrl_valid),  32'd0);
        check_output("rstw_ctrl",        32'(bus.ctrl),        32'd0);
        check_output("rstw_instr_done",  32'(bus.instr_done),  32'd0);
        check_output("rstw_fault",       32'(bus.fault),       32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        apply_stimulus(I_ADD);
        check_output("post_rst_ctrl", 32'(bus.ctrl),       32'h155AAA);
        check_output("post_rst_done", 32'(bus.instr_done), 32'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
